// File: rtl/reg_wb_if.sv
// Register-file write-back bundle: two result producers in, one registered
// register-file write out, plus the pending-write lookup probe.
interface reg_wb_if #(
  parameter int DEPTH = 4
);
  logic                      mem_valid;
  logic [4:0]                mem_addr;
  logic [31:0]               mem_data;
  logic                      mem_ready;
  logic                      alu_valid;
  logic [4:0]                alu_addr;
  logic [31:0]               alu_data;
  logic                      alu_ready;
  logic                      wr_en;
  logic [4:0]                wr_addr;
  logic [31:0]               wr_data;
  logic [4:0]                chk_addr;
  logic                      chk_hit;
  logic [31:0]               chk_data;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, chk_addr,
    input  mem_ready, alu_ready, wr_en, wr_addr, wr_data, chk_hit, chk_data, count
  );

  modport slave (
    input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, chk_addr,
    output mem_ready, alu_ready, wr_en, wr_addr, wr_data, chk_hit, chk_data, count
  );
endinterface

// File: rtl/reg_wb_queue.sv
// In-order write-back FIFO merging MEM and ALU results into one register-file
// write per cycle, with a youngest-match lookup over all pending writes.
module reg_wb_queue #(
  parameter int DEPTH   = 4,
  parameter int DROP_R0 = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  reg_wb_if.slave  wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          wr_en_q;
  logic [4:0]    wr_addr_q;
  logic [31:0]   wr_data_q;

  logic          mem_ready_c;
  logic          alu_ready_c;
  logic          mem_push;
  logic          alu_push;
  logic          pop;
  logic [AW-1:0] alu_slot;

  // Ready looks only at registered occupancy, so a same-cycle pop never widens it.
  assign mem_ready_c = rst_n && (count_q <= CW'(DEPTH - 1));
  assign alu_ready_c = rst_n && ((count_q <= CW'(DEPTH - 2)) ||
                                 ((count_q == CW'(DEPTH - 1)) && !wb.mem_valid));

  assign mem_push = wb.mem_valid && mem_ready_c && ((DROP_R0 == 0) || (wb.mem_addr != 5'd0));
  assign alu_push = wb.alu_valid && alu_ready_c && ((DROP_R0 == 0) || (wb.alu_addr != 5'd0));
  assign pop      = (count_q != '0);
  assign alu_slot = wr_ptr + AW'(mem_push);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (pop) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_q[rd_ptr];
        wr_data_q <= data_q[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end else begin
        wr_en_q   <= 1'b0;
      end
      wr_ptr  <= wr_ptr + AW'(mem_push) + AW'(alu_push);
      count_q <= count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // MEM is the older instruction, so it takes the lower slot on a dual push.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      addr_q[wr_ptr] <= wb.mem_addr;
      data_q[wr_ptr] <= wb.mem_data;
    end
    if (alu_push) begin
      addr_q[alu_slot] <= wb.alu_addr;
      data_q[alu_slot] <= wb.alu_data;
    end
  end

  logic          hit_c;
  logic [31:0]   hit_data_c;
  logic [AW-1:0] idx;

  // Scan oldest to newest so the youngest match is the one left standing.
  always_comb begin
    hit_c      = 1'b0;
    hit_data_c = '0;
    idx        = '0;
    if (wb.chk_addr != 5'd0) begin
      if (wr_en_q && (wr_addr_q == wb.chk_addr)) begin
        hit_c      = 1'b1;
        hit_data_c = wr_data_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + AW'(k);
        if ((CW'(k) < count_q) && (addr_q[idx] == wb.chk_addr)) begin
          hit_c      = 1'b1;
          hit_data_c = data_q[idx];
        end
      end
    end
  end

  assign wb.mem_ready = mem_ready_c;
  assign wb.alu_ready = alu_ready_c;
  assign wb.wr_en     = wr_en_q;
  assign wb.wr_addr   = wr_addr_q;
  assign wb.wr_data   = wr_data_q;
  assign wb.chk_hit   = hit_c;
  assign wb.chk_data  = hit_data_c;
  assign wb.count     = count_q;
endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: scoreboard of pending writes drives expected ready,
// count, register-file writes and lookup results.
module tb_reg_wb_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_if #(.DEPTH(DEPTH)) wb();

  reg_wb_queue #(.DEPTH(DEPTH), .DROP_R0(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  int          m_count = 0;
  logic        m_wr_en = 1'b0;
  logic [4:0]  m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;
  bit          mem_acc;
  bit          alu_acc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check ready/lookup, take the edge, update model, check outputs.
  task automatic step(input bit rn,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic [4:0] ca);
    bit          mr, ar, e_hit;
    logic [31:0] e_data;
    ent_t        e;
    rst_n        = rn;
    wb.mem_valid = mv;
    wb.mem_addr  = ma;
    wb.mem_data  = md;
    wb.alu_valid = av;
    wb.alu_addr  = aa;
    wb.alu_data  = ad;
    wb.chk_addr  = ca;
    mr = rn && (m_count <= DEPTH - 1);
    ar = rn && ((m_count <= DEPTH - 2) || ((m_count == DEPTH - 1) && !mv));
    e_hit  = 1'b0;
    e_data = '0;
    if (ca != 5'd0) begin
      if (m_wr_en && (m_wr_addr == ca)) begin
        e_hit  = 1'b1;
        e_data = m_wr_data;
      end
      foreach (sb[i]) begin
        if (sb[i].addr == ca) begin
          e_hit  = 1'b1;
          e_data = sb[i].data;
        end
      end
    end
    #1;
    check("mem_ready", 32'(wb.mem_ready), 32'(mr));
    check("alu_ready", 32'(wb.alu_ready), 32'(ar));
    if (rn) begin
      check("chk_hit", 32'(wb.chk_hit), 32'(e_hit));
      check("chk_data", wb.chk_data, e_data);
    end
    @(posedge clk);
    if (!rn) begin
      sb.delete();
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
      m_wr_data = '0;
      mem_acc   = 1'b0;
      alu_acc   = 1'b0;
    end else begin
      if (sb.size() > 0) begin
        e         = sb.pop_front();
        m_wr_en   = 1'b1;
        m_wr_addr = e.addr;
        m_wr_data = e.data;
      end else begin
        m_wr_en = 1'b0;
      end
      mem_acc = mv && mr;
      alu_acc = av && ar;
      if (mem_acc && (ma != 5'd0)) sb.push_back(ent_t'({ma, md}));
      if (alu_acc && (aa != 5'd0)) sb.push_back(ent_t'({aa, ad}));
    end
    m_count = sb.size();
    #1;
    check("wr_en", 32'(wb.wr_en), 32'(m_wr_en));
    check("wr_addr", 32'(wb.wr_addr), 32'(m_wr_addr));
    check("wr_data", wb.wr_data, m_wr_data);
    check("count", 32'(wb.count), 32'(m_count));
  endtask

  task automatic idle(input logic [4:0] ca);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ca);
  endtask

  // Producers hold a rejected result until it is accepted.
  task automatic traffic(input int cycles, input int pct, input int amin, input int amax);
    bit          pmv = 1'b0;
    bit          pav = 1'b0;
    logic [4:0]  pma = '0;
    logic [4:0]  paa = '0;
    logic [31:0] pmd = '0;
    logic [31:0] pad = '0;
    for (int c = 0; c < cycles; c++) begin
      if (!pmv && ($urandom_range(99) < pct)) begin
        pmv = 1'b1;
        pma = 5'($urandom_range(amax, amin));
        pmd = $urandom;
      end
      if (!pav && ($urandom_range(99) < pct)) begin
        pav = 1'b1;
        paa = 5'($urandom_range(amax, amin));
        pad = $urandom;
      end
      step(1'b1, pmv, pma, pmd, pav, paa, pad, 5'($urandom_range(7)));
      if (mem_acc) pmv = 1'b0;
      if (alu_acc) pav = 1'b0;
    end
  endtask

  initial begin
    // reset held two edges with both producers asserting
    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd0);
    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd0);
    idle(5'd0);

    // single ALU write and its lookup lifetime
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5);
    repeat (4) idle(5'd5);

    // simultaneous MEM/ALU to the same register
    step(1'b1, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, 5'd3);
    repeat (4) idle(5'd3);

    // saturating traffic with backpressure and pointer wrap
    traffic(12, 100, 1, 7);
    repeat (6) idle(5'd0);

    // register 0 results are accepted and discarded
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0);
    step(1'b1, 1'b1, 5'd0, 32'hEEEE, 1'b1, 5'd0, 32'hDDDD, 5'd0);
    repeat (2) idle(5'd0);

    // reset with three entries queued, then fresh traffic
    step(1'b1, 1'b1, 5'd9, 32'h9009, 1'b1, 5'd10, 32'hA00A, 5'd9);
    step(1'b1, 1'b1, 5'd11, 32'hB00B, 1'b1, 5'd12, 32'hC00C, 5'd12);
    step(1'b0, 1'b1, 5'd13, 32'hD00D, 1'b1, 5'd14, 32'hE00E, 5'd0);
    repeat (3) idle(5'd12);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777, 5'd7);
    repeat (3) idle(5'd7);

    // random mix including register 0 and lookups
    traffic(40, 50, 0, 7);
    repeat (6) idle(5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
